// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes and the CRC16 step used by TX (and later RX).
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;  // x^16+x^15+x^2+1
  localparam logic [15:0] CRC16_POLY_REF = 16'hA001;  // bit-reversed, for LSB-first shifting

  // Advance the CRC16 register by one byte, data bits taken LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_REF;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/if_transceiver.sv
// PHY transceiver bundle. The SIE side drives TX bytes and observes RX/bus reset.
interface if_transceiver;
  logic       usb_reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;

  modport sie (
    input  usb_reset, tx_ready, rx_data, rx_valid, rx_active,
    output tx_data, tx_valid
  );

  modport phy (
    output usb_reset, tx_ready, rx_data, rx_valid, rx_active,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/usb_tx_packet_ctrl.sv
// TX packet sequencer: PID byte, optional FIFO payload, complemented CRC16.
module usb_tx_packet_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_PKT = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  if_transceiver.sie                     transceiver,
  input  logic                           start,
  input  logic [3:0]                     pid,
  input  logic                           with_data,
  input  logic [7:0]                     fifo_q,
  input  logic                           fifo_empty,
  output logic                           fifo_rdreq,
  output logic                           fifo_sclr,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_PKT+1)-1:0]   byte_count
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

  // State names the byte currently presented on tx_data.
  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} tx_state_t;

  tx_state_t      state_q;
  logic [7:0]     tx_data_q;
  logic           tx_valid_q;
  logic           done_q;
  logic           with_data_q;
  logic [15:0]    crc_q;
  logic [CW-1:0]  byte_cnt_q;

  logic want_byte;
  logic take_byte;

  // A next-byte decision is due; pop only if a payload byte is available and allowed.
  always_comb begin
    want_byte = transceiver.tx_ready && !transceiver.usb_reset &&
                ((state_q == S_PID && with_data_q) || state_q == S_DATA);
    take_byte = want_byte && !fifo_empty && (byte_cnt_q < MAX_CNT);
  end

  assign fifo_rdreq           = take_byte && !reset;
  assign fifo_sclr            = transceiver.usb_reset && !reset;
  assign busy                 = (state_q != S_IDLE);
  assign done                 = done_q;
  assign byte_count           = byte_cnt_q;
  assign transceiver.tx_data  = tx_data_q;
  assign transceiver.tx_valid = tx_valid_q;

  // Packet sequencer; bus reset aborts from any state without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      with_data_q <= 1'b0;
      crc_q       <= CRC16_INIT;
      byte_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (transceiver.usb_reset) begin
        state_q    <= S_IDLE;
        tx_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              tx_data_q   <= {~pid, pid};
              tx_valid_q  <= 1'b1;
              crc_q       <= CRC16_INIT;
              byte_cnt_q  <= '0;
              with_data_q <= with_data;
              state_q     <= S_PID;
            end
          end
          S_PID: begin
            if (transceiver.tx_ready && !with_data_q) begin
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
          S_CRC_LO: begin
            if (transceiver.tx_ready) begin
              tx_data_q <= ~crc_q[15:8];
              state_q   <= S_CRC_HI;
            end
          end
          S_CRC_HI: begin
            if (transceiver.tx_ready) begin
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
          default: ;
        endcase

        // Shared next-byte step for PID-with-data and DATA.
        if (want_byte) begin
          if (take_byte) begin
            tx_data_q  <= fifo_q;
            crc_q      <= crc16_byte(crc_q, fifo_q);
            byte_cnt_q <= byte_cnt_q + CW'(1);
            state_q    <= S_DATA;
          end else begin
            tx_data_q <= ~crc_q[7:0];
            state_q   <= S_CRC_LO;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Randomized bench for usb_tx_packet_ctrl against a byte-stream reference model.
module tb_usb_tx_packet_ctrl;
  import usb_pkg::*;

  localparam int MAX_PKT = 8;
  localparam int CW      = $clog2(MAX_PKT + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    pid;
  logic          with_data;
  logic [7:0]    fifo_q;
  logic          fifo_empty;
  logic          fifo_rdreq;
  logic          fifo_sclr;
  logic          busy;
  logic          done;
  logic [CW-1:0] byte_count;

  if_transceiver xcvr ();
  assign xcvr.rx_data   = 8'h00;
  assign xcvr.rx_valid  = 1'b0;
  assign xcvr.rx_active = 1'b0;

  usb_tx_packet_ctrl #(.MAX_PKT(MAX_PKT)) dut (
    .clk(clk), .reset(reset), .transceiver(xcvr.sie),
    .start(start), .pid(pid), .with_data(with_data),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .fifo_sclr(fifo_sclr), .busy(busy), .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model; the initial block only appends, this block only pops.
  logic [7:0] fmem [0:255];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_q     = fmem[rd_ptr];

  always @(posedge clk or posedge reset) begin
    if (reset)           rd_ptr <= 8'd0;
    else if (fifo_sclr)  rd_ptr <= wr_ptr;
    else if (fifo_rdreq) rd_ptr <= rd_ptr + 8'd1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] got [$];

  task automatic load(input logic [7:0] v [$]);
    foreach (v[i]) begin
      fmem[wr_ptr] = v[i];
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  // CRC16 in the non-reflected form: MSB-shift with 0x8005, result bit-reversed.
  function automatic logic [15:0] ref_step(input logic [15:0] r, input logic [7:0] b);
    logic fb;
    for (int k = 0; k < 8; k++) begin
      fb = r[15] ^ b[k];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] r);
    logic [15:0] o;
    for (int k = 0; k < 16; k++) o[k] = r[15-k];
    return o;
  endfunction

  // Start a packet at the current (post-negedge) time and drive tx_ready until done.
  task automatic run_packet(input logic [3:0] p, input bit wd, input int maxgap,
                            input bit poke, input string nm);
    logic [7:0]  exp [$];
    logic [15:0] r;
    logic [15:0] txc;
    logic [7:0]  idx;
    logic [7:0]  prev_data;
    int avail, n, gap, exp_left;
    bit seen_done, bad_pop, bad_stab, bad_done, prev_rdy, prev_vld, stream_ok;

    got.delete();
    avail = int'(8'(wr_ptr - rd_ptr));
    n = 0;
    exp.push_back({~p, p});
    if (wd) begin
      n = (avail < MAX_PKT) ? avail : MAX_PKT;
      r = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
        idx = rd_ptr + 8'(i);
        exp.push_back(fmem[idx]);
        r = ref_step(r, fmem[idx]);
      end
      txc = ~rev16(r);
      exp.push_back(txc[7:0]);
      exp.push_back(txc[15:8]);
    end
    exp_left = avail - n;

    start = 1'b1; pid = p; with_data = wd;
    @(negedge clk);
    start = 1'b0; pid = 4'($urandom); with_data = 1'($urandom);
    n_checks++;
    if (xcvr.tx_valid !== 1'b1 || busy !== 1'b1 || xcvr.tx_data !== exp[0])
      $display("FAIL %s first_byte: valid=%b busy=%b data=%h, want 1 1 %h",
               nm, xcvr.tx_valid, busy, xcvr.tx_data, exp[0]);
    else n_pass++;

    seen_done = 0; bad_pop = 0; bad_stab = 0; bad_done = 0;
    prev_rdy = 0; prev_vld = 0; prev_data = 8'h00;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      start = 1'b0;
      if (poke && cyc == 3 && busy) begin
        start = 1'b1; pid = ~p; with_data = ~wd;
      end
      xcvr.tx_ready = xcvr.tx_valid && (gap == 0);
      #1;
      if (fifo_rdreq && !xcvr.tx_ready) bad_pop = 1;
      if (prev_vld && xcvr.tx_valid && !prev_rdy && xcvr.tx_data !== prev_data) bad_stab = 1;
      if (done) begin
        seen_done = 1;
        if (xcvr.tx_valid || busy || !prev_rdy) bad_done = 1;
      end else begin
        if (xcvr.tx_ready) begin
          got.push_back(xcvr.tx_data);
          gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        end else if (gap > 0) gap--;
        prev_vld = xcvr.tx_valid; prev_rdy = xcvr.tx_ready; prev_data = xcvr.tx_data;
        @(negedge clk);
      end
    end
    xcvr.tx_ready = 1'b0;
    start = 1'b0;

    n_checks++;
    if (!seen_done) $display("FAIL %s timeout: no done within 400 cycles", nm);
    else n_pass++;

    stream_ok = (got.size() == exp.size());
    if (stream_ok) foreach (exp[i]) if (got[i] !== exp[i]) stream_ok = 0;
    n_checks++;
    if (!stream_ok) $display("FAIL %s stream: got %p want %p", nm, got, exp);
    else n_pass++;

    n_checks++;
    if (bad_pop || bad_stab || bad_done)
      $display("FAIL %s handshake: pop_without_ready=%0d unstable_data=%0d done_timing=%0d, want 0 0 0",
               nm, bad_pop, bad_stab, bad_done);
    else n_pass++;

    n_checks++;
    if (byte_count !== CW'(n)) $display("FAIL %s byte_count: got %0d want %0d", nm, byte_count, n);
    else n_pass++;

    n_checks++;
    if (int'(8'(wr_ptr - rd_ptr)) != exp_left)
      $display("FAIL %s fifo_left: got %0d want %0d", nm, 8'(wr_ptr - rd_ptr), exp_left);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; pid = 4'h3; with_data = 1'b1;
    xcvr.usb_reset = 1'b1; xcvr.tx_ready = 1'b1;
    wr_ptr = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (xcvr.tx_valid !== 1'b0 || xcvr.tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        byte_count !== '0 || fifo_rdreq !== 1'b0 || fifo_sclr !== 1'b0)
      $display("FAIL reset_state: valid=%b data=%h busy=%b done=%b cnt=%0d rdreq=%b sclr=%b, want all 0",
               xcvr.tx_valid, xcvr.tx_data, busy, done, byte_count, fifo_rdreq, fifo_sclr);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; xcvr.usb_reset = 1'b0; xcvr.tx_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || xcvr.tx_valid !== 1'b0)
      $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, xcvr.tx_valid);
    else n_pass++;
  endtask

  task automatic test_zero_len;
    run_packet(PID_DATA0, 1'b1, 0, 1'b0, "zero_len");
  endtask

  task automatic test_data1;
    load('{8'h01, 8'h02, 8'h03, 8'h04});
    run_packet(PID_DATA1, 1'b1, 0, 1'b0, "data1_4b");
  endtask

  task automatic test_ack;
    load('{8'hA5, 8'h5A});
    run_packet(PID_ACK, 1'b0, 0, 1'b0, "ack");
  endtask

  task automatic test_max_pkt;
    logic [7:0] v [$];
    for (int i = 0; i < 10; i++) v.push_back(8'($urandom));
    load(v);
    run_packet(PID_DATA0, 1'b1, 2, 1'b0, "max_pkt");
  endtask

  task automatic test_usb_reset;
    load('{8'h11, 8'h22, 8'h33, 8'h44});
    start = 1'b1; pid = PID_DATA0; with_data = 1'b1;
    @(negedge clk);
    start = 1'b0; xcvr.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    xcvr.usb_reset = 1'b1;
    #1;
    n_checks++;
    if (fifo_sclr !== 1'b1 || fifo_rdreq !== 1'b0)
      $display("FAIL usbrst_sclr: sclr=%b rdreq=%b, want 1 0", fifo_sclr, fifo_rdreq);
    else n_pass++;
    @(negedge clk);
    xcvr.tx_ready = 1'b0; start = 1'b1; pid = PID_ACK; with_data = 1'b0;
    #1;
    n_checks++;
    if (xcvr.tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL usbrst_abort: valid=%b done=%b busy=%b, want 0 0 0", xcvr.tx_valid, done, busy);
    else n_pass++;
    @(negedge clk);
    start = 1'b0; xcvr.usb_reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fifo_empty !== 1'b1)
      $display("FAIL usbrst_after: busy=%b done=%b empty=%b, want 0 0 1", busy, done, fifo_empty);
    else n_pass++;
    load('{8'hDE, 8'hAD, 8'hBE});
    run_packet(PID_DATA1, 1'b1, 0, 1'b0, "usbrst_clean");
  endtask

  // Packets started in the very cycle the previous one signals done.
  task automatic test_back_to_back;
    load('{8'h80, 8'h7F, 8'h00});
    run_packet(PID_ACK, 1'b0, 0, 1'b0, "b2b_ack");
    run_packet(PID_NAK, 1'b0, 0, 1'b0, "b2b_nak");
    run_packet(PID_DATA0, 1'b1, 0, 1'b0, "b2b_data");
  endtask

  // Same payload with tx_ready every cycle and with random gaps; start pokes while busy.
  task automatic test_gaps;
    logic [7:0] v [$];
    logic [7:0] saved [$];
    int len;
    bit same;
    for (int it = 0; it < 4; it++) begin
      v.delete();
      len = $urandom_range(0, MAX_PKT);
      for (int i = 0; i < len; i++) v.push_back(8'($urandom));
      load(v);
      run_packet((it % 2) ? PID_DATA1 : PID_DATA0, 1'b1, 0, 1'b0, "gap_fast");
      saved = got;
      @(negedge clk);
      load(v);
      run_packet((it % 2) ? PID_DATA1 : PID_DATA0, 1'b1, 4, 1'b1, "gap_slow");
      same = (saved.size() == got.size());
      if (same) foreach (saved[i]) if (saved[i] !== got[i]) same = 0;
      n_checks++;
      if (!same) $display("FAIL gap_identical: slow %p fast %p", got, saved);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    @(negedge clk);
    test_data1();
    @(negedge clk);
    test_ack();
    @(negedge clk);
    test_usb_reset();
    @(negedge clk);
    test_max_pkt();
    @(negedge clk);
    run_packet(PID_DATA0, 1'b1, 0, 1'b0, "drain");
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_gaps();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_packet_ctrl.md
# usb_tx_packet_ctrl

Transmit-side packet sequencer for the USB device core. On a start request it drives the transceiver TX handshake (`if_transceiver.sie`) to emit one complete packet: PID byte, an optional payload drained from an endpoint FIFO, and the CRC16. It sits between the endpoint/protocol layer (which issues `start`/`pid`) and the PHY (which serialises bytes, bit-stuffs and generates SYNC/EOP).

## Interface
- `MAX_PKT`, 64: maximum payload bytes per packet (1..1023).
- `clk`  input  1  core clock; rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `transceiver`  modport  `if_transceiver.sie`  PHY TX/RX bundle. Only `usb_reset`, `tx_data`, `tx_valid` and `tx_ready` are used; RX signals are ignored.
- `start`  input  1  single-cycle packet request; accepted only while idle.
- `pid`  input  4  PID type code, sampled with `start`.
- `with_data`  input  1  1 = data packet (payload + CRC16); 0 = handshake packet (PID only). Sampled with `start`.
- `fifo_q`  input  8  show-ahead FIFO output; valid whenever `fifo_empty=0`.
- `fifo_empty`  input  1  FIFO empty.
- `fifo_rdreq`  output  1  FIFO pop (combinational).
- `fifo_sclr`  output  1  FIFO flush.
- `busy`  output  1  packet in progress.
- `done`  output  1  one-cycle pulse after the last byte is accepted.
- `byte_count`  output  `$clog2(MAX_PKT+1)`  payload bytes sent in the current/last packet.

## Operation
- States: IDLE, PID, DATA, CRC_LO, CRC_HI. The state names the byte currently presented on `tx_data`.
- IDLE, `start=1`:
  - `tx_data <= {~pid, pid}`; `tx_valid <= 1`.
  - Clear `crc <= 16'hFFFF` and `byte_count <= 0`; latch `with_data`.
  - Go to PID. `start` while not IDLE is ignored.
- On `tx_ready` in PID:
  - `with_data=0`: `tx_valid <= 0`, `done <= 1`, go to IDLE.
  - `with_data=1`: take the next-byte decision below.
- Next-byte decision (`tx_ready` in PID with data, or in DATA):
  - If `byte_count < MAX_PKT` and `fifo_empty=0`:
    - `fifo_rdreq=1` in the same cycle; `tx_data <= fifo_q`.
    - `crc` is updated with `fifo_q`; `byte_count++`; go to DATA.
  - Otherwise: `tx_data <= ~crc_next[7:0]`, go to CRC_LO.
- CRC_LO, `tx_ready`: `tx_data <= ~crc[15:8]`, go to CRC_HI.
- CRC_HI, `tx_ready`: `tx_valid <= 0`, `done <= 1`, go to IDLE.
- CRC16:
  - Polynomial x^16+x^15+x^2+1; init 16'hFFFF.
  - Data is processed LSB-first, over payload bytes only.
  - The complement is transmitted, low byte first.
  - Zero-length payload gives CRC bytes 00 00.
- The packet ends when the FIFO runs empty or `MAX_PKT` bytes have been sent. A FIFO refilled mid-packet is not waited for. The upper layer loads the whole payload before `start`.
- `transceiver.usb_reset=1` in any state:
  - Abort: go to IDLE, `tx_valid <= 0`, no `done`.
  - `fifo_sclr = usb_reset` (combinational).
  - `start` is ignored while `usb_reset=1`.
- `busy = (state != IDLE)`.

## Timing
- Reset values: state IDLE, `tx_valid=0`, `tx_data=8'h00`, `done=0`, `busy=0`, `byte_count=0`, `crc=16'hFFFF`.
- `fifo_rdreq=0` and `fifo_sclr=0` while `reset` is asserted.
- `start` at cycle 0 gives `tx_valid=1` with the PID on `tx_data` at cycle 1.
- `tx_data` is registered. It changes only in the cycle after a `tx_ready`, and is stable while `tx_valid=1` and no `tx_ready` occurs.
- `tx_ready` is a one-cycle pulse from the PHY. The block accepts back-to-back pulses (one per cycle) without byte loss.
- `done` and the `tx_valid` fall occur in the same cycle (1 cycle after the final `tx_ready`). A new `start` is accepted in that same cycle.
- `fifo_rdreq` is asserted only in a cycle with `tx_ready=1`, at most one pop per byte.
- A `usb_reset` that coincides with `tx_ready` has priority: abort, no pop.

## Structure
- Shared package `usb_pkg`:
  - `typedef enum logic [3:0]` for PID codes (OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL).
  - `crc16_byte()` function and the CRC16 init/poly constants, shared with the future RX checker.
- `tx_state_t` is local to the module.
- Single module, no sub-modules.

## Test plan
- ACK handshake (`pid=4'b0010`, `with_data=0`) -> `tx_data` D2, single byte, `done` 1 cycle after `tx_ready`, `fifo_rdreq` never asserted.
- DATA0 zero-length packet, FIFO empty -> bytes C3, 00, 00; `byte_count=0`.
- DATA1 with FIFO holding 01 02 03 04 -> bytes 4B, 01 02 03 04, CRC matching the reference model; 4 pops; `byte_count=4`.
- `MAX_PKT=8`, FIFO holding 10 bytes -> exactly 8 payload bytes, then CRC; FIFO retains 2.
- `usb_reset` asserted during DATA -> `tx_valid` falls next cycle, `fifo_sclr=1`, no `done`; next `start` sends a clean packet.
- `tx_ready` every cycle versus randomly stretched gaps -> identical byte stream; `start` while busy is ignored.
